// File: rtl/mul_sequencer.sv
// Front end for the sequential multiply unit: accepts RV32M multiply ops,
// drives the unit's stb/ack interface and returns the selected/corrected result.
module mul_sequencer #(
    parameter int XLEN        = 32,
    parameter int ZERO_BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [XLEN-1:0]     req_a,
    input  logic [XLEN-1:0]     req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_data,
    output logic [XLEN-1:0]     mul_a,
    output logic [XLEN-1:0]     mul_b,
    output logic                mul_is_signed,
    output logic                mul_stb,
    input  logic                mul_ack,
    input  logic [2*XLEN-1:0]   mul_o
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_rsp_data;

    logic              w_accept;
    logic              w_zero_op;
    logic              w_capture;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_corr;
    logic [XLEN-1:0]   w_result;

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_zero_op = (ZERO_BYPASS != 0) && ((req_a == '0) || (req_b == '0));
    assign w_capture = (r_state == WAIT) && mul_ack;

    // The unit multiplies both operands with one signedness, so MULHSU runs
    // unsigned and subtracts b from the high half when a is negative.
    assign w_hi   = mul_o[2*XLEN-1:XLEN];
    assign w_corr = r_a[XLEN-1] ? r_b : '0;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_result = w_hi;
        case (r_op)
            OP_MUL:    w_result = mul_o[XLEN-1:0];
            OP_MULH:   w_result = w_hi;
            OP_MULHSU: w_result = w_hi - w_corr;
            OP_MULHU:  w_result = w_hi;
            default:   w_result = w_hi;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_next = w_zero_op ? RESP : ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (mul_ack) w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State-decoded outputs; req_ready has no path from req_valid
    always_comb begin
        req_ready = 1'b0;
        mul_stb   = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE:    req_ready = 1'b1;
            ISSUE:   mul_stb   = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand latches and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_op <= req_op;
                r_a  <= req_a;
                r_b  <= req_b;
                if (w_zero_op) r_rsp_data <= '0;
            end
            if (w_capture) r_rsp_data <= w_result;
        end
    end

    assign mul_a         = r_a;
    assign mul_b         = r_b;
    assign mul_is_signed = ~r_op[1];
    assign rsp_data      = r_rsp_data;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: behavioural multiply unit with
// stock latency, table of directed ops, plus stall/spurious-ack/reset sequences.
module tb_mul_sequencer;

    localparam int XLEN    = 32;
    localparam int ACK_DLY = XLEN + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [XLEN-1:0]   req_a;
    logic [XLEN-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic [XLEN-1:0]   mul_a;
    logic [XLEN-1:0]   mul_b;
    logic              mul_is_signed;
    logic              mul_stb;
    logic              mul_ack;
    logic [2*XLEN-1:0] mul_o;

    mul_sequencer #(.XLEN(XLEN), .ZERO_BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_is_signed(mul_is_signed),
        .mul_stb(mul_stb), .mul_ack(mul_ack), .mul_o(mul_o)
    );

    always #5 clk = ~clk;

    // Behavioural multiply unit: sees stb, acks ACK_DLY cycles later.
    logic              model_ack = 1'b0;
    logic [2*XLEN-1:0] model_o   = '0;
    logic [2*XLEN-1:0] model_prod = '0;
    int                model_cnt = 0;
    int                stb_total = 0;
    logic              last_signed = 1'b0;
    logic              spur_ack;
    logic [2*XLEN-1:0] spur_o;

    assign mul_ack = model_ack | spur_ack;
    assign mul_o   = spur_ack ? spur_o : model_o;

    always @(negedge clk) begin
        model_ack = 1'b0;
        if (rst) begin
            model_cnt = 0;
        end else begin
            if (model_cnt > 0) begin
                model_cnt = model_cnt - 1;
                if (model_cnt == 0) begin
                    model_ack = 1'b1;
                    model_o   = model_prod;
                end
            end
            if (mul_stb) begin
                stb_total   = stb_total + 1;
                last_signed = mul_is_signed;
                if (mul_is_signed)
                    model_prod = {{XLEN{mul_a[XLEN-1]}}, mul_a} * {{XLEN{mul_b[XLEN-1]}}, mul_b};
                else
                    model_prod = {{XLEN{1'b0}}, mul_a} * {{XLEN{1'b0}}, mul_b};
                model_cnt = ACK_DLY;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              exp_lat;
        int              exp_stb;
        logic            exp_signed;
    } vec_t;

    // Issue one op, check latency, stb count, signedness and result, then handshake.
    task automatic run_op(input vec_t v, input string tag);
        int stb0;
        int n;
        stb0 = stb_total;
        @(negedge clk);
        check({tag, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(v.exp_lat));
        check({tag, " data"}, 64'(rsp_data), 64'(v.exp));
        check({tag, " stb_pulses"}, 64'(stb_total - stb0), 64'(v.exp_stb));
        if (v.exp_stb != 0) check({tag, " is_signed"}, 64'(last_signed), 64'(v.exp_signed));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " rsp_valid_clr"}, 64'(rsp_valid), 64'd0);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{2'b00, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFA, 36, 1, 1'b1};
        vecs[1]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 36, 1, 1'b1};
        vecs[2]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 36, 1, 1'b0};
        vecs[3]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 36, 1, 1'b0};
        vecs[4]  = '{2'b10, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 36, 1, 1'b0};
        vecs[5]  = '{2'b01, 32'h00000000, 32'h00001234, 32'h00000000, 1, 0, 1'b1};
        vecs[6]  = '{2'b00, 32'h00000007, 32'h00000006, 32'h0000002A, 36, 1, 1'b1};
        vecs[7]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 36, 1, 1'b1};
        vecs[8]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 36, 1, 1'b1};
        vecs[9]  = '{2'b11, 32'h12345678, 32'h00000010, 32'h00000001, 36, 1, 1'b0};
        vecs[10] = '{2'b00, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1, 0, 1'b1};

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b0; spur_ack = 1'b0; spur_o = '0;
        repeat (3) @(negedge clk);
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset mul_stb", 64'(mul_stb), 64'd0);
        check("reset rsp_data", 64'(rsp_data), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Stall in RESP for 5 cycles with a spurious ack carrying garbage.
        begin
            int stb0;
            int n;
            stb0 = stb_total;
            @(negedge clk);
            req_valid = 1'b1; req_op = 2'b00; req_a = 32'd100; req_b = 32'd3;
            @(negedge clk);
            req_valid = 1'b0;
            n = 1;
            while (!rsp_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("stall latency", 64'(n), 64'd36);
            for (int k = 0; k < 5; k++) begin
                spur_ack = (k == 2);
                spur_o   = 64'hA5A5A5A5_5A5A5A5A;
                check("stall rsp_valid", 64'(rsp_valid), 64'd1);
                check("stall rsp_data", 64'(rsp_data), 64'd300);
                check("stall req_ready", 64'(req_ready), 64'd0);
                @(negedge clk);
            end
            spur_ack = 1'b0;
            check("stall post-spur data", 64'(rsp_data), 64'd300);
            check("stall stb_pulses", 64'(stb_total - stb0), 64'd1);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            spur_ack = 1'b1;
            @(negedge clk);
            spur_ack = 1'b0;
            check("idle spur rsp_valid", 64'(rsp_valid), 64'd0);
            check("idle spur req_ready", 64'(req_ready), 64'd1);
            check("idle spur rsp_data", 64'(rsp_data), 64'd300);
        end

        // Reset for one cycle while the op is in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 32'd5; req_b = 32'd5;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("midwait rsp_valid", 64'(rsp_valid), 64'd0);
        check("midwait req_ready", 64'(req_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post-rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("post-rst req_ready", 64'(req_ready), 64'd1);
        check("post-rst mul_stb", 64'(mul_stb), 64'd0);
        repeat (40) @(negedge clk);
        check("post-rst no rsp", 64'(rsp_valid), 64'd0);
        run_op(vecs[6], "post-rst mul7x6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Front end for the sequential multiply unit (`multiply`).
- Accepts RV32M multiply ops (MUL, MULH, MULHSU, MULHU) from the execute stage over a valid/ready handshake.
- Drives the multiply unit's stb/ack interface, then selects and corrects the 2*XLEN product into a registered XLEN result for writeback.
- Handles MULHSU by post-correction, because the multiply unit has a single signedness control shared by both operands.

Parameters:
- XLEN, 32, operand and result width; the multiply unit is instantiated with A_W = B_W = XLEN.
- ZERO_BYPASS, 1, when 1 a zero operand skips the multiply unit and returns 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
- req_a  in  XLEN  rs1 value
- req_b  in  XLEN  rs2 value
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  XLEN  result
- mul_a  out  XLEN  to multiply.a
- mul_b  out  XLEN  to multiply.b
- mul_is_signed  out  1  to multiply.is_signed
- mul_stb  out  1  to multiply.stb
- mul_ack  in  1  from multiply.ack
- mul_o  in  2*XLEN  from multiply.o

Behaviour:
- Reset: state IDLE; req_ready=1 after reset; rsp_valid=0, mul_stb=0, rsp_data=0, operand/op registers=0.
- Reset mid-operation: abandons any in-flight op, with no response produced. The multiply unit shares rst, so nothing is left pending.
- States: IDLE, ISSUE, WAIT, RESP.
- req_ready = (state==IDLE); it is a registered or state-decoded output with no combinational path from req_valid.
- IDLE, on req_valid:
  - Latches op, a and b.
  - If ZERO_BYPASS && (req_a==0 || req_b==0): rsp_data<=0 and go to RESP. Response is valid the next cycle, and mul_stb is never asserted.
  - Otherwise go to ISSUE.
- ISSUE:
  - mul_stb=1 for exactly one cycle, then go to WAIT.
  - mul_stb must never be high for more than one cycle. The multiply unit re-samples if stb is high in its ack cycle.
- Operand drive:
  - mul_a, mul_b and mul_is_signed come from the latched registers and are stable from ISSUE through WAIT.
  - mul_is_signed = 1 for MUL and MULH, 0 for MULHSU and MULHU.
- WAIT: on mul_ack, capture the result into rsp_data and go to RESP.
  - MUL: mul_o[XLEN-1:0].
  - MULH, MULHU: mul_o[2*XLEN-1:XLEN].
  - MULHSU: mul_o[2*XLEN-1:XLEN] - (a_lat[XLEN-1] ? b_lat : 0), modulo 2^XLEN.
- mul_ack outside WAIT is ignored.
- RESP: rsp_valid=1; rsp_data is held stable until rsp_ready. On the handshake, clear rsp_valid and go to IDLE. A new request is accepted no earlier than the cycle after the handshake.
- Latency, request accepted at cycle T:
  - ISSUE at T+1.
  - rsp_valid rises the cycle after mul_ack, which is T+XLEN+4 with the stock multiply unit.
  - The sequencer does not count cycles; it relies only on mul_ack.
- Throughput: at most one op outstanding.

Test Plan:
- MUL a=3, b=0xFFFFFFFE -> rsp_data=0xFFFFFFFA; exactly one mul_stb pulse; rsp_valid the cycle after mul_ack (T+36 with XLEN=32).
- MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; mul_is_signed=1 and 0 respectively.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF (correction applied); MULHSU a=0x00000002, b=0xFFFFFFFF -> 0x00000001 (no correction).
- MULH a=0, b=0x1234 with ZERO_BYPASS=1 -> rsp_valid at T+1, rsp_data=0, mul_stb never high.
- rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0; a spurious mul_ack pulse in RESP or IDLE changes nothing.
- rst asserted for 1 cycle mid-WAIT -> next cycle IDLE, rsp_valid=0, req_ready=1; a following MUL 7*6 returns 42.
